sd_read_arbiter: RTL and testbench
==================================

Name: sd_read_arbiter

Overview:
- Shares the single SPI-mode SD card controller between NUM_REQ block-read requesters, e.g. a frame loader and an audio streamer.
- Arbitrates round-robin and drives the controller's read_enable/address pair.
- Counts the 512 returned bytes and steers each one, with its byte index, to the granted requester.
- Signals completion, or a stall error if the controller stops delivering bytes.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BLOCK_BYTES, 512, bytes per block read.
- TIMEOUT_CYCLES, 5_000_000, max clk cycles allowed between successive bytes; also applies to first byte after issue.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester read request (level); hold until done/error
- req_addr  in  32*NUM_REQ  block address; requester i uses bits [32*i+31:32*i]
- grant  out  NUM_REQ  one-hot; set while requester owns the card
- rd_data  out  8  byte to the granted requester
- rd_valid  out  NUM_REQ  one-hot 1-cycle byte strobe
- rd_index  out  9  index (0..511) of byte on rd_data
- done  out  NUM_REQ  one-hot 1-cycle pulse after last byte
- error  out  NUM_REQ  one-hot 1-cycle pulse on timeout
- sd_ready  in  1  controller idle/initialised
- sd_read_enable  out  1  read command to controller
- sd_address  out  32  block address to controller
- sd_data  in  8  controller byte output
- sd_data_ready  in  1  controller byte strobe

Behaviour:
- Reset (async, active-high) state values:
  - all outputs 0; state IDLE;
  - rr_ptr = NUM_REQ-1, so requester 0 wins first; byte_cnt = 0; timer = 0.
- sd_data_ready is edge-detected. One byte is accepted per rising edge (registered previous value), so a strobe wider than one clk counts once.
- IDLE:
  - When sd_ready=1 and req≠0, pick the first asserted req searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Latch its index, set grant, latch req_addr into sd_address, go ISSUE.
  - While sd_ready=0, no grant is made.
- ISSUE:
  - sd_read_enable=1 until sd_ready falls; then sd_read_enable=0 and go STREAM.
  - The timer runs from entry; on timeout go ERR.
- STREAM, on each accepted byte:
  - registered rd_data = sd_data; rd_index = byte_cnt; rd_valid[g] = 1 for one cycle; byte_cnt++; timer cleared.
  - When the byte with byte_cnt = BLOCK_BYTES-1 is accepted, go WAIT_RDY.
  - Byte-to-rd_valid latency is 1 clk after the detected edge.
  - If timer reaches TIMEOUT_CYCLES-1 with no byte, go ERR.
- WAIT_RDY:
  - Ignore further strobes (CRC/poll); wait for sd_ready=1.
  - Then pulse done[g] for 1 cycle, drop grant, rr_ptr = g, byte_cnt = 0, go IDLE.
  - Timeout also applies here and goes to ERR.
- ERR:
  - Pulse error[g] for 1 cycle, drop grant, rr_ptr = g, byte_cnt = 0, return to IDLE.
  - The next grant waits until sd_ready.
- Requester behaviour during a transaction:
  - Deasserting req mid-transaction does not abort; the block still completes.
  - req_addr changes after grant are ignored.
- Simultaneous requests: resolved strictly round-robin. A requester holding req continuously is served at most once per NUM_REQ grants while others wait.
- Byte count: byte_cnt is 10 bits and never wraps; exactly BLOCK_BYTES rd_valid pulses per successful transaction.
- Timer: saturating counter, width clog2(TIMEOUT_CYCLES).
- sd_read_enable is never asserted outside ISSUE.
- Reset mid-transaction aborts immediately with no done/error pulse. The controller is reset by the same reset.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding localparams: IDLE, ISSUE, STREAM, WAIT_RDY, ERR;
  - SD_BLOCK_BYTES = 512;
  - default timeout constant.
- One natural sub-module: rr_arbiter.
  - Parameterised NUM_REQ; inputs req, rr_ptr; outputs one-hot gnt and index.
  - Purely combinational; reused elsewhere.

Test Plan:
- Single request: req=01, req_addr0=0x00000010 → sd_address=0x10 and sd_read_enable high until sd_ready falls; 512 bytes fed → 512 rd_valid[0] pulses, rd_index 0..511 in order, one done[0] after sd_ready returns.
- Contention: req=11 from reset → requester 0 served first, then 1. Requester 0 re-raises req during 1's transfer → next grant is 0, and rd_valid[1] never fires during 0's transfer.
- Wide strobe: sd_data_ready held high 3 cycles per byte → still exactly 512 rd_valid pulses, with matching data.
- Stall: with TIMEOUT_CYCLES=1000, stop strobes after byte 100 → error[g] pulse 1000 cycles after last byte; no done; grant cleared; next request served normally.
- sd_ready low at request: req=01 while sd_ready=0 → no grant or sd_read_enable until sd_ready=1.
- Async reset in STREAM at byte 300 → all outputs 0 immediately; no done/error; fresh request afterwards restarts at rd_index 0.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD block-read arbiter
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    STREAM   = 3'd2,
    WAIT_RDY = 3'd3,
    ERR      = 3'd4
  } sd_state_e;

  localparam int SD_BLOCK_BYTES     = 512;
  localparam int SD_TIMEOUT_DEFAULT = 5_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from rr_ptr+1
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int  cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/sd_read_arbiter.sv
// rtl/sd_read_arbiter.sv - shares one SPI-mode SD controller between block-read requesters
module sd_read_arbiter
  import sd_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BLOCK_BYTES    = SD_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = SD_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      grant,
  output logic [7:0]              rd_data,
  output logic [NUM_REQ-1:0]      rd_valid,
  output logic [8:0]              rd_index,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      error,
  input  logic                    sd_ready,
  output logic                    sd_read_enable,
  output logic [31:0]             sd_address,
  input  logic [7:0]              sd_data,
  input  logic                    sd_data_ready
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  sd_state_e            state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        g_q, g_d;
  logic [9:0]           byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 prev_q, prev_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
  logic [8:0]           rd_index_q, rd_index_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   error_q, error_d;
  logic [31:0]          sd_address_q, sd_address_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic [NUM_REQ-1:0]   g_onehot;
  logic                 byte_stb;
  logic                 timed_out;
  logic [TW-1:0]        timer_inc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  // A strobe held high for several clocks is one byte: only its rising edge counts.
  assign prev_d    = sd_data_ready;
  assign byte_stb  = sd_data_ready & ~prev_q;
  assign g_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << g_q;
  assign timed_out = (timer_q >= TW'(TIMEOUT_CYCLES-1));
  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    g_d          = g_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    grant_d      = grant_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = '0;
    rd_index_d   = rd_index_q;
    done_d       = '0;
    error_d      = '0;
    sd_address_d = sd_address_q;
    case (state_q)
      IDLE: begin
        if (sd_ready && |req) begin
          g_d          = arb_idx;
          grant_d      = arb_gnt;
          sd_address_d = req_addr[32*arb_idx +: 32];
          timer_d      = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_inc;
        if (timed_out)      state_d = ERR;
        else if (!sd_ready) state_d = STREAM;
      end
      STREAM: begin
        if (byte_stb) begin
          rd_data_d  = sd_data;
          rd_index_d = byte_cnt_q[8:0];
          rd_valid_d = g_onehot;
          byte_cnt_d = byte_cnt_q + 10'd1;
          timer_d    = '0;
          if (byte_cnt_q == 10'(BLOCK_BYTES-1)) state_d = WAIT_RDY;
        end else begin
          timer_d = timer_inc;
          if (timed_out) state_d = ERR;
        end
      end
      WAIT_RDY: begin
        // Trailing CRC/poll strobes land here and are deliberately dropped.
        if (sd_ready) begin
          done_d     = g_onehot;
          grant_d    = '0;
          rr_ptr_d   = g_q;
          byte_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_inc;
          if (timed_out) state_d = ERR;
        end
      end
      ERR: begin
        error_d    = g_onehot;
        grant_d    = '0;
        rr_ptr_d   = g_q;
        byte_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IW'(NUM_REQ-1);
      g_q          <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      prev_q       <= 1'b0;
      grant_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
      rd_index_q   <= '0;
      done_q       <= '0;
      error_q      <= '0;
      sd_address_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      g_q          <= g_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      prev_q       <= prev_d;
      grant_q      <= grant_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_index_q   <= rd_index_d;
      done_q       <= done_d;
      error_q      <= error_d;
      sd_address_q <= sd_address_d;
    end
  end

  // The read command drops the moment the controller goes busy.
  assign sd_read_enable = (state_q == ISSUE) && sd_ready;
  assign grant          = grant_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign rd_index       = rd_index_q;
  assign done           = done_q;
  assign error          = error_q;
  assign sd_address     = sd_address_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb/tb_sd_read_arbiter.sv - randomized scoreboard bench for sd_read_arbiter
module tb_sd_read_arbiter;

  localparam int NR  = 2;
  localparam int TO  = 1000;
  localparam int BB  = 512;
  localparam int K_BYTE = 0, K_DONE = 1, K_ERR = 2;

  typedef struct {
    int         kind;
    int         who;
    logic [7:0] data;
    int         idx;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [32*NR-1:0]  req_addr;
  logic [NR-1:0]     grant;
  logic [7:0]        rd_data;
  logic [NR-1:0]     rd_valid;
  logic [8:0]        rd_index;
  logic [NR-1:0]     done;
  logic [NR-1:0]     error;
  logic              sd_ready;
  logic              sd_read_enable;
  logic [31:0]       sd_address;
  logic [7:0]        sd_data;
  logic              sd_data_ready;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_now  = 0;
  ev_t  exp_q[$];
  logic [NR-1:0] reqv;
  int   last;

  sd_read_arbiter #(.NUM_REQ(NR), .BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .grant(grant),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index), .done(done),
    .error(error), .sd_ready(sd_ready), .sd_read_enable(sd_read_enable),
    .sd_address(sd_address), .sd_data(sd_data), .sd_data_ready(sd_data_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference round-robin: first requester after the last one served.
  function automatic int pick(input logic [NR-1:0] r, input int lst);
    for (int k = 1; k <= NR; k++)
      if (r[(lst + k) % NR]) return (lst + k) % NR;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      if (sd_read_enable) check("enable_without_grant", 64'(grant != '0), 64'd1);
      if ((|rd_valid) || (|done) || (|error)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: rd_valid=%b done=%b error=%b expected none", rd_valid, done, error);
        end else begin
          ev_t e;
          logic [NR-1:0] oh;
          e  = exp_q.pop_front();
          oh = NR'(1) << e.who;
          check("rd_valid", 64'(rd_valid), 64'((e.kind == K_BYTE) ? oh : '0));
          check("done",     64'(done),     64'((e.kind == K_DONE) ? oh : '0));
          check("error",    64'(error),    64'((e.kind == K_ERR)  ? oh : '0));
          if (e.kind == K_BYTE) begin
            check("rd_data",  64'(rd_data),  64'(e.data));
            check("rd_index", 64'(rd_index), 64'(e.idx));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},      64'(grant),          64'd0);
    check({tag, "_rd_valid"},   64'(rd_valid),       64'd0);
    check({tag, "_rd_data"},    64'(rd_data),        64'd0);
    check({tag, "_rd_index"},   64'(rd_index),       64'd0);
    check({tag, "_done"},       64'(done),           64'd0);
    check({tag, "_error"},      64'(error),          64'd0);
    check({tag, "_enable"},     64'(sd_read_enable), 64'd0);
    check({tag, "_sd_address"}, 64'(sd_address),     64'd0);
  endtask

  // mode: 0 normal, 1 wide strobes, 2 stall after byte 100, 3 reset at byte 300
  task automatic serve(input int who, input logic [31:0] addr_exp, input int mode);
    int cyc;
    int t0;
    logic [7:0] d;
    cyc = 0;
    while (!sd_read_enable && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("issue_seen", 64'(sd_read_enable), 64'd1);
    check("grant", 64'(grant), 64'(NR'(1) << who));
    check("sd_address", 64'(sd_address), 64'(addr_exp));
    req_addr = {$urandom, $urandom};
    tick(2);
    check("enable_held", 64'(sd_read_enable), 64'd1);
    check("address_ignores_change", 64'(sd_address), 64'(addr_exp));
    sd_ready = 1'b0;
    #1;
    check("enable_drop", 64'(sd_read_enable), 64'd0);
    tick(1);
    for (int b = 0; b < BB; b++) begin
      if (mode == 3 && b == 300) begin
        tick(3);
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        check("abort_queue_drained", 64'(exp_q.size()), 64'd0);
        req = '0;
        sd_data_ready = 1'b0;
        tick(3);
        sd_ready = 1'b1;
        reset = 1'b0;
        return;
      end
      if (b == 256) begin
        for (int i = 0; i < NR; i++)
          if (i != who && $urandom_range(0, 1) == 1) reqv[i] = 1'b1;
        if ($urandom_range(0, 1) == 1) reqv[who] = 1'b0;
        req = reqv;
      end
      tick($urandom_range(0, 2));
      d = 8'($urandom);
      sd_data = d;
      sd_data_ready = 1'b1;
      t0 = cyc_now;
      exp_q.push_back('{K_BYTE, who, d, b});
      tick((mode == 1) ? 3 : $urandom_range(1, 2));
      sd_data_ready = 1'b0;
      tick(1);
      if (mode == 2 && b == 100) begin
        exp_q.push_back('{K_ERR, who, 8'h00, 0});
        cyc = 0;
        while (error == '0 && cyc < TO + 50) begin
          tick(1);
          cyc++;
        end
        check("stall_error", 64'(error), 64'(NR'(1) << who));
        check("stall_delay_ok", 64'((cyc_now - t0) >= TO && (cyc_now - t0) <= TO + 4), 64'd1);
        check("stall_grant_cleared", 64'(grant), 64'd0);
        sd_ready = 1'b1;
        return;
      end
    end
    repeat (2) begin
      sd_data_ready = 1'b1;
      tick(1);
      sd_data_ready = 1'b0;
      tick(1);
    end
    exp_q.push_back('{K_DONE, who, 8'h00, 0});
    sd_ready = 1'b1;
    cyc = 0;
    while (done == '0 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    check("done_seen", 64'(done), 64'(NR'(1) << who));
    check("grant_after_done", 64'(grant), 64'd0);
  endtask

  initial begin
    int who;
    int mode;
    logic [31:0] ea;
    reset = 1'b1;
    req = '0;
    reqv = '0;
    last = NR - 1;
    req_addr = {32'hCAFE0000, 32'h00000010};
    sd_ready = 1'b0;
    sd_data = 8'h00;
    sd_data_ready = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    reqv = 2'b11;
    req = reqv;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("no_grant_not_ready", 64'(grant), 64'd0);
      check("no_enable_not_ready", 64'(sd_read_enable), 64'd0);
    end
    sd_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      mode = (t == 4) ? 1 : (t == 7) ? 2 : (t == 10) ? 3 : 0;
      if (reqv == '0) reqv = NR'($urandom_range(1, (1 << NR) - 1));
      if (t > 0) req_addr = {$urandom, $urandom};
      who = pick(reqv, last);
      ea = req_addr[32*who +: 32];
      req = reqv;
      serve(who, ea, mode);
      if (mode == 3) begin
        last = NR - 1;
        reqv = '0;
      end else begin
        last = who;
        reqv[who] = 1'b0;
      end
      req = reqv;
    end
    tick(5);
    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
